// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the five-stage RV32I pipeline: post-reset clear, hazard and
// memory-wait stalls, redirect flushes, data-memory timeout. Define PIPE_STALL_CTRL_PERF_EN for stall/flush counters.
module pipe_stall_ctrl #(
  parameter int INIT_FLUSH_CYCLES = 4,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard,
  input  logic             branch_taken_ex,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_e;

  // Wait counter must reach MEM_TIMEOUT and still have room to saturate above it.
  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
  localparam logic [3:0]        INIT_LAST   = 4'(INIT_FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              resolve;
  logic              stall_inc;
  logic              flush_inc;

  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b1;
    mem_wb_bubble = 1'b0;
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    resolve       = 1'b0;
    flush_inc     = 1'b0;

    case (state_q)
      S_INIT: begin
        pc_we         = 1'b0;
        if_id_flush   = 1'b1;
        id_ex_bubble  = 1'b1;
        mem_wb_bubble = 1'b1;
        init_cnt_d    = init_cnt_q + 4'd1;
        if (init_cnt_q == INIT_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (dmem_req && !dmem_ready) begin
          pc_we         = 1'b0;
          if_id_we      = 1'b0;
          id_ex_we      = 1'b0;
          ex_mem_we     = 1'b0;
          mem_wb_bubble = 1'b1;
          state_d       = S_MEM_WAIT;
          wait_cnt_d    = WAIT_W'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_we         = 1'b0;
          if_id_we      = 1'b0;
          id_ex_we      = 1'b0;
          ex_mem_we     = 1'b0;
          mem_wb_bubble = 1'b1;
          if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_VAL)) begin
            state_d       = S_HALT;
            mem_timeout_d = 1'b1;
          end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          resolve    = 1'b1;
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        id_ex_we  = 1'b0;
        ex_mem_we = 1'b0;
      end
    endcase

    // Redirect beats load-use, which beats a fetch miss.
    if (resolve) begin
      if (branch_taken_ex) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        flush_inc    = 1'b1;
      end else if (load_use_hazard) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (!imem_ready) begin
        pc_we       = 1'b0;
        if_id_flush = 1'b1;
      end
    end

    stall_inc = ((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !pc_we;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      init_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = stall_inc ^ flush_inc;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Table-driven bench for pipe_stall_ctrl; expectations flow through a scoreboard queue.
module tb_pipe_stall_ctrl;
  localparam int CNT_W = 16;
`ifdef PIPE_STALL_CTRL_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // Output bundle order: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble}
  localparam logic [6:0] O_INIT = 7'b0111111;
  localparam logic [6:0] O_RUN  = 7'b1101010;
  localparam logic [6:0] O_MEM  = 7'b0000001;
  localparam logic [6:0] O_BR   = 7'b1111110;
  localparam logic [6:0] O_LU   = 7'b0001110;
  localparam logic [6:0] O_IM   = 7'b0111010;
  localparam logic [6:0] O_HALT = 7'b0000000;

  logic clk = 1'b0;
  logic rst_n, loadUse, branchTaken, imemReady, dmemReq, dmemReady;
  logic pcWe, ifIdWe, ifIdFlush, idExWe, idExBubble, exMemWe, memWbBubble, memTimeout;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  pipe_stall_ctrl #(
    .INIT_FLUSH_CYCLES(4),
    .MEM_TIMEOUT(5),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_use_hazard(loadUse),
    .branch_taken_ex(branchTaken),
    .imem_ready(imemReady),
    .dmem_req(dmemReq),
    .dmem_ready(dmemReady),
    .pc_we(pcWe),
    .if_id_we(ifIdWe),
    .if_id_flush(ifIdFlush),
    .id_ex_we(idExWe),
    .id_ex_bubble(idExBubble),
    .ex_mem_we(exMemWe),
    .mem_wb_bubble(memWbBubble),
    .mem_timeout(memTimeout),
    .stall_cnt(stallCnt),
    .flush_cnt(flushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstN;
    logic       lu;
    logic       br;
    logic       imem;
    logic       req;
    logic       rdy;
    logic [6:0] expOut;
    logic       expTo;
    logic       live;
  } vec_t;

  typedef struct {
    int               id;
    logic [6:0]       out;
    logic             to;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int testsRun = 0;
  int testsFailed = 0;
  logic [CNT_W-1:0] modelStall = '0;
  logic [CNT_W-1:0] modelFlush = '0;

  function automatic vec_t mk(input logic r, input logic lu, input logic br, input logic im,
                              input logic rq, input logic rd, input logic [6:0] o,
                              input logic t, input logic live);
    vec_t v;
    v.rstN = r; v.lu = lu; v.br = br; v.imem = im; v.req = rq; v.rdy = rd;
    v.expOut = o; v.expTo = t; v.live = live;
    return v;
  endfunction

  // Counters observed this cycle reflect all earlier cycles; update the model after pushing.
  task automatic applyStimulus(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    rst_n = v.rstN; loadUse = v.lu; branchTaken = v.br;
    imemReady = v.imem; dmemReq = v.req; dmemReady = v.rdy;
    e.id = id; e.out = v.expOut; e.to = v.expTo;
    e.stall = PERF_EN ? modelStall : '0;
    e.flush = PERF_EN ? modelFlush : '0;
    sb.push_back(e);
    if (!v.rstN) begin
      modelStall = '0;
      modelFlush = '0;
    end else if (v.live) begin
      if (!v.expOut[6]) modelStall = modelStall + CNT_W'(1);
      if (v.expOut[6] && v.expOut[4]) modelFlush = modelFlush + CNT_W'(1);
    end
  endtask

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, id, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    #2;
    if (sb.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    cmp("ctrl", e.id, 32'({pcWe, ifIdWe, ifIdFlush, idExWe, idExBubble, exMemWe, memWbBubble}), 32'(e.out));
    cmp("mem_timeout", e.id, 32'(memTimeout), 32'(e.to));
    cmp("stall_cnt", e.id, 32'(stallCnt), 32'(e.stall));
    cmp("flush_cnt", e.id, 32'(flushCnt), 32'(e.flush));
  endtask

  initial begin
    rst_n = 1'b0; loadUse = 1'b0; branchTaken = 1'b0;
    imemReady = 1'b1; dmemReq = 1'b0; dmemReady = 1'b0;

    // INIT ignores every input for four cycles.
    tbl.push_back(mk(1, 1,1,0,1,0, O_INIT, 0, 0));
    tbl.push_back(mk(1, 0,0,1,0,0, O_INIT, 0, 0));
    tbl.push_back(mk(1, 1,0,1,1,0, O_INIT, 0, 0));
    tbl.push_back(mk(1, 0,1,1,0,1, O_INIT, 0, 0));
    tbl.push_back(mk(1, 0,0,1,0,0, O_RUN,  0, 1));
    tbl.push_back(mk(1, 1,0,1,0,0, O_LU,   0, 1));
    tbl.push_back(mk(1, 0,0,1,0,0, O_RUN,  0, 1));
    tbl.push_back(mk(1, 1,1,1,0,0, O_BR,   0, 1));
    tbl.push_back(mk(1, 0,0,0,0,0, O_IM,   0, 1));
    tbl.push_back(mk(1, 1,0,0,0,0, O_LU,   0, 1));
    tbl.push_back(mk(1, 0,1,0,0,0, O_BR,   0, 1));
    tbl.push_back(mk(1, 0,0,1,1,1, O_RUN,  0, 1));
    tbl.push_back(mk(1, 0,0,1,0,1, O_RUN,  0, 1));
    // Three-cycle memory wait, redirect held pending until the access completes.
    tbl.push_back(mk(1, 1,1,1,1,0, O_MEM,  0, 1));
    tbl.push_back(mk(1, 0,1,1,1,0, O_MEM,  0, 1));
    tbl.push_back(mk(1, 0,0,1,1,0, O_MEM,  0, 1));
    tbl.push_back(mk(1, 0,1,1,1,1, O_BR,   0, 1));
    tbl.push_back(mk(1, 0,0,1,0,0, O_RUN,  0, 1));
    tbl.push_back(mk(1, 0,0,1,1,0, O_MEM,  0, 1));
    tbl.push_back(mk(1, 1,0,1,1,1, O_LU,   0, 1));
    tbl.push_back(mk(1, 0,0,1,0,0, O_RUN,  0, 1));
    // Timeout: RUN entry plus five MEM_WAIT cycles, then HALT.
    for (int k = 0; k < 6; k++) tbl.push_back(mk(1, 0,0,1,1,0, O_MEM, 0, 1));
    tbl.push_back(mk(1, 0,1,1,1,0, O_HALT, 1, 0));
    tbl.push_back(mk(1, 1,0,1,1,1, O_HALT, 1, 0));
    tbl.push_back(mk(0, 0,0,1,0,0, O_HALT, 1, 0));
    tbl.push_back(mk(1, 1,1,1,1,0, O_INIT, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0,0,1,0,0, O_INIT, 0, 0));
    tbl.push_back(mk(1, 0,0,1,0,0, O_RUN,  0, 1));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i], i);
      checkOutput();
    end

    // Memory wait ending into a fetch miss, then reset asserted mid-wait.
    applyStimulus(mk(1, 0,0,1,1,0, O_MEM,  0, 1), 100); checkOutput();
    applyStimulus(mk(1, 0,0,0,1,1, O_IM,   0, 1), 101); checkOutput();
    applyStimulus(mk(1, 0,0,1,1,0, O_MEM,  0, 1), 102); checkOutput();
    applyStimulus(mk(0, 0,0,1,1,0, O_MEM,  0, 0), 103); checkOutput();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(mk(1, 1,1,1,1,0, O_INIT, 0, 0), 104 + k);
      checkOutput();
    end
    applyStimulus(mk(1, 0,0,1,0,0, O_RUN,  0, 1), 108); checkOutput();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
